// File: rtl/tank_pkg.sv
// Shared types and defaults for the tank fill/drain controller.
// Counter widths come from cnt_width so every counter is just wide enough for its terminal value.
package tank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } tank_state_e;

    localparam int DEF_W         = 8;
    localparam int DEF_LOW_TH    = 20;
    localparam int DEF_MID_TH    = 50;
    localparam int DEF_HIGH_TH   = 90;
    localparam int DEF_MIN_RUN   = 16;
    localparam int DEF_STALL_CYC = 1024;
    localparam int DEF_AVG_LOG2  = 2;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tank_level_ctrl_if.sv
// Sampler-side and pump/indicator-side signals of the tank controller.
// Handshake: level_valid qualifies level_in for exactly one cycle; there is no backpressure,
// every valid sample is consumed on the edge it is presented. fault_clr is a one-cycle pulse.
interface tank_level_ctrl_if #(
    parameter int W = 8
);

    logic [W-1:0]         level_in;
    logic                 level_valid;
    logic                 fault_clr;
    logic                 fill_pump;
    logic                 drain_pump;
    logic                 zone_l;
    logic                 zone_m;
    logic                 zone_h;
    logic                 trend;
    logic                 fault;
    logic [W-1:0]         level_filt;
    tank_pkg::tank_state_e dbg_state;

    modport master (
        output level_in, level_valid, fault_clr,
        input  fill_pump, drain_pump, zone_l, zone_m, zone_h, trend, fault, level_filt,
        input  dbg_state
    );

    modport slave (
        input  level_in, level_valid, fault_clr,
        output fill_pump, drain_pump, zone_l, zone_m, zone_h, trend, fault, level_filt,
        output dbg_state
    );

endinterface

// File: rtl/level_avg_filter.sv
// Moving average over the last 2**AVG_LOG2 valid samples using a shift history and running sum.
// filt holds 0 until the history has been filled once (primed).
module level_avg_filter #(
    parameter int W        = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] sample,
    input  logic         sample_valid,
    output logic [W-1:0] filt,
    output logic         primed
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] N_C = CW'(N);

    logic [W-1:0]  hist_q [N];
    logic [W-1:0]  hist_d [N];
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  filt_q, filt_d;

    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sample_valid) begin
            for (int i = N - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0] = sample;
            // The sum always contains the oldest entry, so this never underflows.
            sum_d = sum_q + SW'(sample) - SW'(hist_q[N-1]);
            if (cnt_q != N_C) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cnt_d == N_C) begin
                filt_d = W'(sum_d >> AVG_LOG2);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= '0;
            end
            sum_q  <= '0;
            cnt_q  <= '0;
            filt_q <= '0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt   = filt_q;
    assign primed = (cnt_q == N_C);

endmodule

// File: rtl/tank_level_ctrl.sv
// Fill/drain pump controller: averaged level, hysteresis with minimum dwell, stall fault.
// Pumps, fault and trend are decoded from registered state so they change on the same edge.
module tank_level_ctrl
    import tank_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int LOW_TH    = DEF_LOW_TH,
    parameter int MID_TH    = DEF_MID_TH,
    parameter int HIGH_TH   = DEF_HIGH_TH,
    parameter int MIN_RUN   = DEF_MIN_RUN,
    parameter int STALL_CYC = DEF_STALL_CYC,
    parameter int AVG_LOG2  = DEF_AVG_LOG2
) (
    input  logic             clock,
    input  logic             reset,
    tank_level_ctrl_if.slave bus
);

    localparam int DW  = cnt_width(MIN_RUN);
    localparam int SCW = cnt_width(STALL_CYC - 1);

    localparam logic [W-1:0]   LOW_W      = W'(LOW_TH);
    localparam logic [W-1:0]   MID_W      = W'(MID_TH);
    localparam logic [W-1:0]   HIGH_W     = W'(HIGH_TH);
    localparam logic [DW-1:0]  MIN_RUN_C  = DW'(MIN_RUN);
    localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_CYC - 1);

    if (!(LOW_TH > 0 && LOW_TH < MID_TH && MID_TH < HIGH_TH && HIGH_TH < (1 << W) &&
          MIN_RUN >= 1 && STALL_CYC > MIN_RUN)) begin : g_param_check
        $error("tank_level_ctrl: illegal threshold or timing parameters");
    end

    logic [W-1:0] filt;
    logic         primed;

    level_avg_filter #(
        .W        (W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_filter (
        .clock        (clock),
        .reset        (reset),
        .sample       (bus.level_in),
        .sample_valid (bus.level_valid),
        .filt         (filt),
        .primed       (primed)
    );

    tank_state_e    state_q, state_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [SCW-1:0] stall_q, stall_d;
    logic [W-1:0]   prev_q, prev_d;
    logic           trend_q, trend_d;
    logic [2:0]     zone_q, zone_d;

    logic dwell_done;
    logic stalled;
    logic progress;
    logic entering;

    assign dwell_done = (dwell_q >= MIN_RUN_C);
    assign stalled    = (stall_q == STALL_LAST);

    // Stall has priority over a threshold crossing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (primed) begin
                    state_d = (filt >= HIGH_W) ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (stalled) begin
                    state_d = FAULT;
                end else if (filt >= HIGH_W && dwell_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (stalled) begin
                    state_d = FAULT;
                end else if (filt <= LOW_W && dwell_done) begin
                    state_d = FILL;
                end
            end
            FAULT: begin
                if (bus.fault_clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        entering = (state_d != state_q);
        progress = (state_q == FILL  && filt > prev_q) ||
                   (state_q == DRAIN && filt < prev_q);
        prev_d   = filt;

        dwell_d = dwell_q;
        if (entering) begin
            dwell_d = '0;
        end else if (dwell_q < MIN_RUN_C) begin
            dwell_d = dwell_q + DW'(1);
        end

        stall_d = stall_q + SCW'(1);
        if (entering || progress || !(state_q == FILL || state_q == DRAIN)) begin
            stall_d = '0;
        end
    end

    always_comb begin
        trend_d = trend_q;
        if (state_d == FILL) begin
            trend_d = 1'b1;
        end else if (state_d == DRAIN) begin
            trend_d = 1'b0;
        end

        // zone_d = {h, m, l}
        zone_d = 3'b000;
        if (primed) begin
            if (filt < MID_W) begin
                zone_d = 3'b001;
            end else if (filt < HIGH_W) begin
                zone_d = 3'b010;
            end else begin
                zone_d = 3'b100;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dwell_q <= '0;
            stall_q <= '0;
            prev_q  <= '0;
            trend_q <= 1'b1;
            zone_q  <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            stall_q <= stall_d;
            prev_q  <= prev_d;
            trend_q <= trend_d;
            zone_q  <= zone_d;
        end
    end

    assign bus.fill_pump  = (state_q == FILL);
    assign bus.drain_pump = (state_q == DRAIN);
    assign bus.fault      = (state_q == FAULT);
    assign bus.trend      = trend_q;
    assign bus.zone_l     = zone_q[0];
    assign bus.zone_m     = zone_q[1];
    assign bus.zone_h     = zone_q[2];
    assign bus.level_filt = filt;
    assign bus.dbg_state  = state_q;

endmodule
